// File: rtl/pipe_stage_buf.sv
// Two-entry in-order pipeline register (head + skid) with hold,
// flush and a saturating bubble counter for the consumer side.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              hold,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [1:0]        occ_q, occ_d;
   logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d;
   logic [DATA_W-1:0] h_data_q, h_data_d;
   logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic              run_q;
   logic              push;
   logic              pop;

   // handshake flags: run_q keeps in_ready low until one edge past reset
   always_comb begin
      in_ready  = run_q && (occ_q != 2'd2) && !hold;
      out_valid = (occ_q != 2'd0) && !hold;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      occupancy = occ_q;
      out_ctrl  = (occ_q != 2'd0) ? h_ctrl_q : '0;
      out_data  = (occ_q != 2'd0) ? h_data_q : '0;
   end

   // next buffer contents; flush beats hold beats push/pop
   always_comb begin
      occ_d    = occ_q;
      h_ctrl_d = h_ctrl_q;
      h_data_d = h_data_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      if (flush) begin
         occ_d    = 2'd0;
         h_ctrl_d = '0;
         h_data_d = '0;
         s_ctrl_d = '0;
         s_data_d = '0;
      end else if (!hold) begin
         unique case (occ_q)
            2'd0: begin
               if (push) begin
                  occ_d    = 2'd1;
                  h_ctrl_d = in_ctrl;
                  h_data_d = in_data;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  h_ctrl_d = in_ctrl;
                  h_data_d = in_data;
               end else if (push) begin
                  occ_d    = 2'd2;
                  s_ctrl_d = in_ctrl;
                  s_data_d = in_data;
               end else if (pop) begin
                  occ_d    = 2'd0;
                  h_ctrl_d = '0;
                  h_data_d = '0;
               end
            end
            2'd2: begin
               if (pop) begin
                  occ_d    = 2'd1;
                  h_ctrl_d = s_ctrl_q;
                  h_data_d = s_data_q;
                  s_ctrl_d = '0;
                  s_data_d = '0;
               end
            end
            default: begin
               occ_d = 2'd0;
            end
         endcase
      end
   end

   // buffer state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q    <= 2'd0;
         h_ctrl_q <= '0;
         h_data_q <= '0;
         s_ctrl_q <= '0;
         s_data_q <= '0;
         run_q    <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         h_ctrl_q <= h_ctrl_d;
         h_data_q <= h_data_d;
         s_ctrl_q <= s_ctrl_d;
         s_data_q <= s_data_d;
         run_q    <= 1'b1;
      end
   end

   // saturating count of cycles the consumer waited on an empty stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt <= '0;
      end else if (out_ready && !out_valid && !hold
                   && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload word (IR, PC, results, operands packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8: width of the control-flag vector (RegWrite, MemToReg, JAL, SYSCALL, ...), which is zeroed on flush.
REQ-003 Parameter CNT_W, default 16: width of the bubble counter.
REQ-004 Port list: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  upstream stage presents a word.
REQ-008 in_ready  out  1  stage accepts a word this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control flags.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  head entry is presented downstream.
REQ-012 out_ready  in  1  downstream consumes the head entry.
REQ-013 out_ctrl  out  CTRL_W  head control flags.
REQ-014 out_data  out  DATA_W  head payload.
REQ-015 hold  in  1  freeze request (hazard stall).
REQ-016 flush  in  1  synchronous kill of all buffered entries (branch/exception).
REQ-017 occupancy  out  2  number of valid entries, 0..2.
REQ-018 bubble_cnt  out  CNT_W  cycles in which the consumer was ready and no word was presented.

Function
REQ-019 Storage SHALL be a 2-entry in-order buffer (head + skid); words leave in acceptance order.
REQ-020 in_ready SHALL equal (occupancy < 2) AND NOT hold, and SHALL depend only on registered state and hold, never on out_ready.
REQ-021 Push occurs on a rising edge with in_valid AND in_ready; pop occurs with out_valid AND out_ready.
REQ-022 out_valid SHALL equal (occupancy != 0) AND NOT hold; while hold=1 no push and no pop occur and all stored state is unchanged.
REQ-023 Latency: a word pushed into an empty buffer at edge N SHALL appear on out_* after edge N and stay stable until popped.
REQ-024 Push and pop in the same cycle at occupancy 1: occupancy stays 1 and the head becomes the newly pushed word.
REQ-025 Push without pop at occupancy 1 SHALL place the word in the skid entry; pop at occupancy 2 SHALL promote the skid entry to the head.
REQ-026 At occupancy 2 in_ready=0, so no push occurs; in_valid is ignored.
REQ-027 At occupancy 0, out_ctrl and out_data SHALL be all-zero, so no stale control flags are presented.
REQ-028 flush=1 at an edge SHALL set occupancy to 0 and both entries to all-zero, and SHALL discard any simultaneous push or pop.
REQ-029 Priority SHALL be flush > hold > push/pop.
REQ-030 bubble_cnt SHALL increment by 1 at each edge where out_ready=1, out_valid=0 and hold=0, and SHALL saturate at 2^CNT_W-1.
REQ-031 bubble_cnt is not cleared by flush.

Reset
REQ-032 rst=0 SHALL immediately, without waiting for a clock edge, force occupancy=0, out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, and in_ready=0.
REQ-033 Reset asserted mid-transfer SHALL drop all buffered words.
REQ-034 On the first edge after rst rises, in_ready SHALL be 1 if hold=0.

Verification
REQ-035 Stream with out_ready=1: push data 0x11,0x22,0x33 on consecutive cycles -> the same words appear one cycle later in order, occupancy stays 1, and in_ready stays 1.
REQ-036 Backpressure with out_ready=0: push 0xA, then 0xB -> occupancy=2 and in_ready=0; 0xC held on the input is not accepted; raising out_ready drains 0xA then 0xB, and 0xC is accepted after the first pop.
REQ-037 Flush at occupancy 2 with in_valid=1 and data 0xD -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and 0xD is discarded.
REQ-038 hold=1 for 3 cycles at occupancy 1 with in_valid=1 -> in_ready=0, out_valid=0, and head data unchanged; after hold drops the head is presented again and the pending word is accepted.
REQ-039 Idle, out_ready=1, CNT_W=4, 20 cycles -> bubble_cnt saturates at 15.
REQ-040 Assert rst=0 between clock edges at occupancy 2 -> all outputs are zero before the next edge; after release and 1 edge, in_ready=1.
